ad9434_spi_target: RTL and testbench

//  SPI target (responder) that models the AD9434 ADC serial control port.
//  It receives 24-bit frames: a 16-bit instruction followed by 8 bits of data.

---
 rtl/ad9434_spi_target.sv | 251 +++++++++++++++++++++++++
 tb/tb_ad9434_spi_target.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ad9434_spi_target.sv
// AD9434-style SPI control-port responder: 24-bit frames (16-bit instr + 8-bit data), shadow/active regs.
// Latency: pins act SYNC_STAGES+1 clk after they change; no backpressure, the SPI master owns all timing.
module ad9434_spi_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CHIP_ID     = 8'h6A,
  parameter logic [7:0]  CHIP_GRADE  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sclk,
  input  logic       i_csb,
  input  logic       i_sdi,
  output logic       o_sdo,
  output logic       o_sdo_oe,
  output logic [7:0] o_output_mode,
  output logic [7:0] o_ovr_cfg,
  output logic [7:0] o_flex_vref,
  output logic [7:0] o_test_io,
  output logic       o_update,
  output logic       o_frame_err
);

  typedef enum logic [2:0] {S_IDLE, S_INSTR, S_WDATA, S_RDATA, S_SKIP} state_t;

  localparam int unsigned NREG = 11;
  localparam logic [3:0] SL_00 = 4'd0, SL_0D = 4'd1, SL_14 = 4'd3, SL_18 = 4'd7;
  localparam logic [3:0] SL_2A = 4'd8, SL_FF = 4'd10, SL_NONE = 4'd15;

  function automatic logic [3:0] slot_of(input logic [12:0] a);
    case (a)
      13'h000: slot_of = SL_00;
      13'h00D: slot_of = SL_0D;
      13'h00F: slot_of = 4'd2;
      13'h014: slot_of = SL_14;
      13'h015: slot_of = 4'd4;
      13'h016: slot_of = 4'd5;
      13'h017: slot_of = 4'd6;
      13'h018: slot_of = SL_18;
      13'h02A: slot_of = SL_2A;
      13'h02C: slot_of = 4'd9;
      13'h0FF: slot_of = SL_FF;
      default: slot_of = SL_NONE;
    endcase
  endfunction

  function automatic logic [7:0] rst_val(input logic [3:0] s);
    case (s)
      SL_00:   rst_val = 8'h18;
      SL_2A:   rst_val = 8'h01;
      default: rst_val = 8'h00;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic       sclk_q, sclk_d, armed_q, armed_d;
  logic       sclk_s, csb_s, sdi_s, rise, fall;
  state_t     state_q, state_d;
  logic [4:0] bitcnt_q, bitcnt_d;
  logic [14:0] instr_q, instr_d;
  logic [12:0] addr_q, addr_d;
  logic [6:0] data_q, data_d;
  logic [7:0] rd_shift_q, rd_shift_d;
  logic [2:0] rd_cnt_q, rd_cnt_d;
  logic       sdo_q, sdo_d, sdo_oe_q, sdo_oe_d;
  logic       update_q, update_d, frame_err_q, frame_err_d;
  logic [7:0] shadow_q [NREG];
  logic [7:0] shadow_d [NREG];
  logic [7:0] act_om_q, act_om_d, act_ovr_q, act_ovr_d;
  logic [7:0] act_fv_q, act_fv_d, act_tio_q, act_tio_d;
  logic [15:0] instr_full;
  logic [7:0] wr_full, rd_val;
  logic [3:0] rd_slot, wr_slot;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign csb_s  = csb_sync_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_q;
  assign fall   = ~sclk_s & sclk_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
    csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], i_csb};
    sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], i_sdi};
    sclk_d      = sclk_s;
    // Only start frames after csb has been seen high, so a frame cut by rst is ignored to its end.
    armed_d     = armed_q | csb_s;
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rd_shift_d  = rd_shift_q;
    rd_cnt_d    = rd_cnt_q;
    sdo_d       = sdo_q;
    sdo_oe_d    = sdo_oe_q;
    update_d    = 1'b0;
    frame_err_d = 1'b0;
    shadow_d    = shadow_q;
    act_om_d    = act_om_q;
    act_ovr_d   = act_ovr_q;
    act_fv_d    = act_fv_q;
    act_tio_d   = act_tio_q;

    instr_full = {instr_q, sdi_s};
    wr_full    = {data_q, sdi_s};
    rd_slot    = slot_of(instr_full[12:0]);
    wr_slot    = slot_of(addr_q);
    rd_val     = 8'h00;
    if (instr_full[12:0] == 13'h001) rd_val = CHIP_ID;
    else if (instr_full[12:0] == 13'h002) rd_val = CHIP_GRADE;
    else begin
      for (int i = 0; i < NREG; i++) if (rd_slot == 4'(i)) rd_val = shadow_q[i];
    end

    if (state_q != S_IDLE && csb_s) begin
      state_d  = S_IDLE;
      bitcnt_d = '0;
      sdo_d    = 1'b0;
      sdo_oe_d = 1'b0;
      if (state_q != S_SKIP) frame_err_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!csb_s && armed_q) begin
            state_d  = S_INSTR;
            bitcnt_d = '0;
          end
        end
        S_INSTR: begin
          if (rise) begin
            instr_d  = instr_full[14:0];
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd15) begin
              addr_d = instr_full[12:0];
              if (instr_full[14:13] != 2'b00) begin
                frame_err_d = 1'b1;
                state_d     = S_SKIP;
              end else if (instr_full[15]) begin
                rd_shift_d = rd_val;
                rd_cnt_d   = '0;
                state_d    = S_RDATA;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end
        S_WDATA: begin
          if (rise) begin
            data_d   = wr_full[6:0];
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd23) begin
              state_d = S_SKIP;
              if (wr_slot == SL_00 && (wr_full[5] || wr_full[2])) begin
                for (int i = 0; i < NREG; i++) shadow_d[i] = rst_val(4'(i));
                act_om_d  = rst_val(SL_14);
                act_ovr_d = rst_val(SL_2A);
                act_fv_d  = rst_val(SL_18);
                act_tio_d = rst_val(SL_0D);
              end else if (wr_slot == SL_FF) begin
                // Transfer bit self-clears in the same clk that loads the active set.
                shadow_d[SL_FF] = {wr_full[7:1], 1'b0};
                if (wr_full[0]) begin
                  act_om_d  = shadow_q[SL_14];
                  act_ovr_d = shadow_q[SL_2A];
                  act_fv_d  = shadow_q[SL_18];
                  act_tio_d = shadow_q[SL_0D];
                  update_d  = 1'b1;
                end
              end else if (wr_slot == SL_00) begin
                shadow_d[SL_00] = wr_full & 8'hDB;
              end else begin
                for (int i = 0; i < NREG; i++) if (wr_slot == 4'(i)) shadow_d[i] = wr_full;
              end
            end
          end
        end
        S_RDATA: begin
          if (fall) begin
            sdo_d      = rd_shift_q[7];
            sdo_oe_d   = 1'b1;
            rd_shift_d = {rd_shift_q[6:0], 1'b0};
            rd_cnt_d   = rd_cnt_q + 3'd1;
            if (rd_cnt_q == 3'd7) state_d = S_SKIP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      csb_sync_q  <= '0;
      sdi_sync_q  <= '0;
      sclk_q      <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      instr_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_shift_q  <= '0;
      rd_cnt_q    <= '0;
      sdo_q       <= 1'b0;
      sdo_oe_q    <= 1'b0;
      update_q    <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NREG; i++) shadow_q[i] <= rst_val(4'(i));
      act_om_q    <= rst_val(SL_14);
      act_ovr_q   <= rst_val(SL_2A);
      act_fv_q    <= rst_val(SL_18);
      act_tio_q   <= rst_val(SL_0D);
    end else begin
      sclk_sync_q <= sclk_sync_d;
      csb_sync_q  <= csb_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      sclk_q      <= sclk_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rd_shift_q  <= rd_shift_d;
      rd_cnt_q    <= rd_cnt_d;
      sdo_q       <= sdo_d;
      sdo_oe_q    <= sdo_oe_d;
      update_q    <= update_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < NREG; i++) shadow_q[i] <= shadow_d[i];
      act_om_q    <= act_om_d;
      act_ovr_q   <= act_ovr_d;
      act_fv_q    <= act_fv_d;
      act_tio_q   <= act_tio_d;
    end
  end

  assign o_sdo         = sdo_q;
  assign o_sdo_oe      = sdo_oe_q;
  assign o_update      = update_q;
  assign o_frame_err   = frame_err_q;
  assign o_output_mode = act_om_q;
  assign o_ovr_cfg     = act_ovr_q;
  assign o_flex_vref   = act_fv_q;
  assign o_test_io     = act_tio_q;

endmodule

// File: tb/tb_ad9434_spi_target.sv
// Scoreboarded bench for ad9434_spi_target: driver pushes expected per-frame results, monitor observes pins.
module tb_ad9434_spi_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_sclk, i_csb, i_sdi;
  logic       o_sdo, o_sdo_oe, o_update, o_frame_err;
  logic [7:0] o_output_mode, o_ovr_cfg, o_flex_vref, o_test_io;

  ad9434_spi_target #(.SYNC_STAGES(2), .CHIP_ID(8'h6A), .CHIP_GRADE(8'h00)) dut (
    .clk(clk), .rst(rst), .i_sclk(i_sclk), .i_csb(i_csb), .i_sdi(i_sdi),
    .o_sdo(o_sdo), .o_sdo_oe(o_sdo_oe), .o_output_mode(o_output_mode),
    .o_ovr_cfg(o_ovr_cfg), .o_flex_vref(o_flex_vref), .o_test_io(o_test_io),
    .o_update(o_update), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         rd;
    int         rdbits;
    int         errs;
    int         upds;
    logic [7:0] om, ovr, fv, tio;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   req_seq = 0;
  int   done_seq = 0;
  int   fidx = 0;
  logic [7:0] e_om, e_ovr, e_fv, e_tio;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: accumulates pulses and sdo bits, compares against the scoreboard at each frame boundary.
  initial begin : monitor
    exp_t e;
    int   rd, rdbits, errs, upds, n;
    logic sclk_prev;
    rd = 0; rdbits = 0; errs = 0; upds = 0; n = 0; sclk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_frame_err) errs++;
        if (o_update) upds++;
        if (i_sclk && !sclk_prev && o_sdo_oe) begin
          rd = ((rd << 1) | int'(o_sdo)) & 8'hFF;
          rdbits++;
        end
        if (req_seq != done_seq) begin
          if (exp_q.size() == 0) begin
            check($sformatf("f%0d_scoreboard_empty", n), 1, 0);
          end else begin
            e = exp_q.pop_front();
            if (e.rdbits > 0) check($sformatf("f%0d_rd_data", n), rd, e.rd);
            check($sformatf("f%0d_rd_bits", n), rdbits, e.rdbits);
            check($sformatf("f%0d_frame_err", n), errs, e.errs);
            check($sformatf("f%0d_update", n), upds, e.upds);
            check($sformatf("f%0d_sdo_oe_idle", n), int'(o_sdo_oe), 0);
            check($sformatf("f%0d_sdo_idle", n), int'(o_sdo), 0);
            check($sformatf("f%0d_output_mode", n), int'(o_output_mode), int'(e.om));
            check($sformatf("f%0d_ovr_cfg", n), int'(o_ovr_cfg), int'(e.ovr));
            check($sformatf("f%0d_flex_vref", n), int'(o_flex_vref), int'(e.fv));
            check($sformatf("f%0d_test_io", n), int'(o_test_io), int'(e.tio));
          end
          rd = 0; rdbits = 0; errs = 0; upds = 0; n++;
          done_seq = req_seq;
        end
      end
      sclk_prev = i_sclk;
    end
  end

  task automatic push_exp(input int rd, input int rdbits, input int errs, input int upds);
    exp_t e;
    e.rd = rd; e.rdbits = rdbits; e.errs = errs; e.upds = upds;
    e.om = e_om; e.ovr = e_ovr; e.fv = e_fv; e.tio = e_tio;
    exp_q.push_back(e);
  endtask

  task automatic request_check();
    int n;
    req_seq++;
    n = 0;
    while (done_seq != req_seq && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (done_seq != req_seq) begin
      $display("FAIL monitor_timeout: frame %0d not checked within %0d clks", fidx, n);
      $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
      $fatal(1, "monitor stalled");
    end
    fidx++;
  endtask

  // sclk half period of 80 ns = 8 clk, comfortably above SYNC_STAGES+2.
  task automatic spi_frame(input logic [15:0] instr, input logic [7:0] data, input int nbits);
    logic [23:0] w;
    w = {instr, data};
    i_csb = 1'b0;
    #100;
    for (int b = 0; b < nbits; b++) begin
      i_sdi = w[23-b];
      #80 i_sclk = 1'b1;
      #80 i_sclk = 1'b0;
    end
    #100 i_csb = 1'b1;
    #200;
  endtask

  task automatic xfer(input logic [15:0] instr, input logic [7:0] data, input int nbits,
                      input int rd, input int rdbits, input int errs, input int upds);
    push_exp(rd, rdbits, errs, upds);
    spi_frame(instr, data, nbits);
    request_check();
  endtask

  task automatic wr(input logic [12:0] a, input logic [7:0] d, input int upds);
    xfer({3'b000, a}, d, 24, 0, 0, 0, upds);
  endtask

  task automatic rd(input logic [12:0] a, input int expv);
    xfer({3'b100, a}, 8'h00, 24, expv, 8, 0, 0);
  endtask

  initial begin : driver
    rst = 1'b1; i_csb = 1'b1; i_sclk = 1'b0; i_sdi = 1'b0;
    e_om = 8'h00; e_ovr = 8'h01; e_fv = 8'h00; e_tio = 8'h00;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);

    // reset state
    push_exp(0, 0, 0, 0);
    request_check();

    // chip id read
    rd(13'h001, 8'h6A);

    // shadow vs active, then transfer
    wr(13'h02A, 8'h03, 0);
    rd(13'h02A, 8'h03);
    e_ovr = 8'h03;
    wr(13'h0FF, 8'h01, 1);
    rd(13'h0FF, 8'h00);

    // read-only and unmapped
    wr(13'h001, 8'h55, 0);
    rd(13'h001, 8'h6A);
    rd(13'h002, 8'h00);
    rd(13'h1234, 8'h00);

    // aborted write after 20 bits
    xfer(16'h0014, 8'h77, 20, 0, 0, 1, 0);
    rd(13'h014, 8'h00);
    wr(13'h014, 8'h5A, 0);
    rd(13'h014, 8'h5A);

    // unsupported W field
    xfer(16'h2014, 8'hAA, 24, 0, 0, 1, 0);
    rd(13'h014, 8'h5A);

    // commit then soft reset
    wr(13'h00D, 8'h0A, 0);
    e_tio = 8'h0A; e_om = 8'h5A; e_ovr = 8'h03;
    wr(13'h0FF, 8'h01, 1);
    e_tio = 8'h00; e_om = 8'h00; e_ovr = 8'h01; e_fv = 8'h00;
    wr(13'h000, 8'h24, 0);
    rd(13'h000, 8'h18);
    rd(13'h02A, 8'h01);
    rd(13'h00D, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
